// File: rtl/hidman_zx_bus_ctrl_pkg.sv
// hidman_zx_pkg: shared constants for the HIDman ZX Spectrum bus controller.
// Holds the Kempston port numbers, the register reset values, the CH446Q
// matrix dimensions and the coordinates of the three special-key outputs.
package hidman_zx_pkg;

  // Low address byte decoded for each Kempston port
  localparam logic [7:0] MOUSE_PORT = 8'hDF;
  localparam logic [7:0] JOY_PORT   = 8'h1F;

  // Reset values of the button and joystick registers
  localparam logic [7:0] MKEY_RST = 8'hFF;
  localparam logic [7:0] JOY_RST  = 8'h00;

  // Crosspoint matrix: rows map to A8..A15, columns map to D0..D4
  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 5;

  // Special keys live outside the matrix at X=8
  localparam logic [3:0] SPECIAL_X = 4'd8;
  localparam logic [2:0] NMI_Y     = 3'd5;
  localparam logic [2:0] RST_Y     = 3'd6;
  localparam logic [2:0] BSRQ_Y    = 3'd7;

  // Kempston mouse readback: buttons with bit 3 forced high, X, or Y,
  // selected by A8 and A10.
  function automatic logic [7:0] mouse_read(input logic a8, input logic a10,
                                            input logic [7:0] mkey,
                                            input logic [7:0] mx,
                                            input logic [7:0] my);
    if (!a8)       return mkey | 8'h08;
    else if (!a10) return mx;
    else           return my;
  endfunction

endpackage

// File: rtl/hidman_zx_bus_ctrl_if.sv
// hidman_zx_bus_if: groups the HID-controller write side, the Z80 bus
// control/address side and the special-key outputs of hidman_zx_bus_ctrl.
//   slave  : view used by the controller block itself
//   master : view used by whatever drives the block (controller + Z80)
// The data bus D is a tri-state pin and stays a plain port on the top.
interface hidman_zx_bus_if;
  // HID controller writes
  logic       MX;
  logic       MY;
  logic       MKEY;
  logic       JOY;
  logic [7:0] DI;
  logic       JOY_ENABLE;
  // CH446Q-style serial load
  logic       DAT;
  logic       SK;
  logic       STB;
  // Z80 side
  logic [15:0] A;
  logic        M1;
  logic        RD;
  logic        IORQ;
  logic        TAPE_IN;
  logic        IORQGE;
  // Special keys
  logic        NMI;
  logic        RST_OUT;
  logic        BSRQ;

  modport slave (
    input  MX, MY, MKEY, JOY, DI, JOY_ENABLE, DAT, SK, STB,
    input  A, M1, RD, IORQ, TAPE_IN,
    output IORQGE, NMI, RST_OUT, BSRQ
  );

  modport master (
    output MX, MY, MKEY, JOY, DI, JOY_ENABLE, DAT, SK, STB,
    output A, M1, RD, IORQ, TAPE_IN,
    input  IORQGE, NMI, RST_OUT, BSRQ
  );
endinterface

// File: rtl/hidman_zx_bus_ctrl_ch446q_matrix.sv
// ch446q_matrix: emulation of a CH446Q 8x5 crosspoint switch as used for
// the ZX keyboard, plus three special-key latches.
//   clk, rst_n   : clock, synchronous active-low reset
//   dat_i        : serial data / switch value
//   sk_rise_i    : shift pulse (already synchronised)
//   stb_rise_i   : commit pulse (already synchronised)
//   row_n_i      : A15..A8, a 0 selects that row
//   cols_o       : row-AND of selected rows, 0 = key closed
//   nmi_o, rst_o, bsrq_o : special-key outputs
//   addr_o       : current shift-register contents {Y[2:0], X[3:0]}
module ch446q_matrix
  import hidman_zx_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dat_i,
  input  logic                   sk_rise_i,
  input  logic                   stb_rise_i,
  input  logic [MATRIX_ROWS-1:0] row_n_i,
  output logic [MATRIX_COLS-1:0] cols_o,
  output logic                   nmi_o,
  output logic                   rst_o,
  output logic                   bsrq_o,
  output logic [6:0]             addr_o
);

  logic [6:0]                                shift_q;
  logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0]   closed_q;  // 1 = switch closed
  logic                                      nmi_q, rst_q, bsrq_q;
  logic [3:0]                                sw_x;
  logic [2:0]                                sw_y;
  logic                                      in_matrix;

  // Serial order is Y2,Y1,Y0,X3..X0, so after seven shifts Y sits on top
  assign sw_y      = shift_q[6:4];
  assign sw_x      = shift_q[3:0];
  assign in_matrix = (sw_x < 4'(MATRIX_ROWS)) && (sw_y < 3'(MATRIX_COLS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q  <= '0;
      closed_q <= '0;
      nmi_q    <= 1'b0;
      rst_q    <= 1'b0;
      bsrq_q   <= 1'b0;
    end else begin
      if (sk_rise_i) shift_q <= {shift_q[5:0], dat_i};
      // A commit coinciding with a shift uses the address before the shift
      if (stb_rise_i) begin
        if (in_matrix) begin
          closed_q[sw_x[2:0]][sw_y] <= dat_i;
        end else if (sw_x == SPECIAL_X) begin
          if (sw_y == NMI_Y)  nmi_q  <= dat_i;
          if (sw_y == RST_Y)  rst_q  <= dat_i;
          if (sw_y == BSRQ_Y) bsrq_q <= dat_i;
        end
      end
    end
  end

  always_comb begin
    cols_o = '1;
    for (int r = 0; r < MATRIX_ROWS; r++) begin
      if (!row_n_i[r]) cols_o = cols_o & ~closed_q[r];
    end
  end

  assign nmi_o  = nmi_q;
  assign rst_o  = rst_q;
  assign bsrq_o = bsrq_q;
  assign addr_o = shift_q;

endmodule

// File: rtl/hidman_zx_bus_ctrl_sync_edge.sv
// hidman_zx_sync_edge: brings one asynchronous strobe into the clk domain
// through a STAGES-deep flop chain and emits a one-cycle pulse on its
// synchronised rising edge.
//   clk, rst_n : clock, synchronous active-low reset
//   async_i    : raw strobe
//   rise_o     : one-cycle pulse, STAGES cycles after the strobe is sampled
module hidman_zx_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              last_q;
  logic [STAGES:0]   chain;

  // Shift chain built one bit wider so STAGES=1 needs no special case
  assign chain  = {sync_q, async_i};
  assign sync_d = chain[STAGES-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/hidman_zx_bus_ctrl.sv
// hidman_zx_bus_ctrl: ZX Spectrum bus side of the HIDman adapter.
// Holds the Kempston mouse and joystick registers written by the HID
// controller, the CH446Q keyboard matrix, and answers Z80 IN cycles.
//   CLK, RST_IN : clock, synchronous active-low reset
//   bus         : controller strobes/data, Z80 control/address, IORQGE,
//                 special-key outputs (hidman_zx_bus_if.slave)
//   D           : tri-state read data, driven only while IORQGE is high
// Handshake: a controller write is a strobe rising edge with DI/DAT held
// stable from one CLK before until SYNC_STAGES+1 CLK after; a Z80 read is
// IORQ=0, RD=0, M1=1, and the block answers combinationally.
module hidman_zx_bus_ctrl
  import hidman_zx_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MX_RST      = 8'h80,
  parameter logic [7:0] MY_RST      = 8'h60
) (
  input  logic               CLK,
  input  logic               RST_IN,
  hidman_zx_bus_if.slave     bus,
  output wire  [7:0]         D
);

  // Strobe index order: 0 MX, 1 MY, 2 MKEY, 3 JOY, 4 SK, 5 STB
  logic [5:0] strobe_raw;
  logic [5:0] strobe_rise;

  logic [7:0] mx_q, my_q, mkey_q, joy_q;
  logic [MATRIX_COLS-1:0] kb_cols;
  logic [6:0] kb_addr;

  logic       rd_cyc;
  logic       hit;
  logic [7:0] rd_data;

  assign strobe_raw = {bus.STB, bus.SK, bus.JOY, bus.MKEY, bus.MY, bus.MX};

  for (genvar i = 0; i < 6; i++) begin : g_sync
    hidman_zx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (CLK),
      .rst_n   (RST_IN),
      .async_i (strobe_raw[i]),
      .rise_o  (strobe_rise[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_IN) begin
      mx_q   <= MX_RST;
      my_q   <= MY_RST;
      mkey_q <= MKEY_RST;
      joy_q  <= JOY_RST;
    end else begin
      if (strobe_rise[0]) mx_q   <= bus.DI;
      if (strobe_rise[1]) my_q   <= bus.DI;
      if (strobe_rise[2]) mkey_q <= bus.DI;
      if (strobe_rise[3]) joy_q  <= bus.DI;
    end
  end

  ch446q_matrix u_matrix (
    .clk        (CLK),
    .rst_n      (RST_IN),
    .dat_i      (bus.DAT),
    .sk_rise_i  (strobe_rise[4]),
    .stb_rise_i (strobe_rise[5]),
    .row_n_i    (bus.A[15:8]),
    .cols_o     (kb_cols),
    .nmi_o      (bus.NMI),
    .rst_o      (bus.RST_OUT),
    .bsrq_o     (bus.BSRQ),
    .addr_o     (kb_addr)
  );

  assign rd_cyc = ~bus.IORQ & ~bus.RD & bus.M1;

  // Decode order: mouse, joystick, keyboard. Both Kempston ports are odd
  // addresses, so they never collide with the keyboard's A0=0 decode.
  always_comb begin
    hit     = 1'b0;
    rd_data = 8'hFF;
    if (bus.A[7:0] == MOUSE_PORT) begin
      hit     = 1'b1;
      rd_data = mouse_read(bus.A[8], bus.A[10], mkey_q, mx_q, my_q);
    end else if (bus.A[7:0] == JOY_PORT && !bus.JOY_ENABLE) begin
      hit     = 1'b1;
      rd_data = joy_q;
    end else if (!bus.A[0]) begin
      hit     = 1'b1;
      rd_data = {1'b1, bus.TAPE_IN, 1'b1, kb_cols};
    end
  end

  assign bus.IORQGE = rd_cyc & hit;
  assign D          = (rd_cyc & hit) ? rd_data : 8'hzz;

  // Shift-register contents are only observed for debug
  logic unused_ok;
  assign unused_ok = ^kb_addr;

endmodule

// File: tb/tb_hidman_zx_bus_ctrl.sv
// Directed bench for hidman_zx_bus_ctrl: Kempston registers, joystick
// enable, keyboard matrix row-AND, special keys and a one-cycle reset.
module tb_hidman_zx_bus_ctrl;

  logic       clk;
  logic       rst_n;
  wire  [7:0] d;

  int tests = 0;
  int fails = 0;

  hidman_zx_bus_if bus ();

  hidman_zx_bus_ctrl #(
    .SYNC_STAGES (2),
    .MX_RST      (8'h80),
    .MY_RST      (8'h60)
  ) dut (
    .CLK    (clk),
    .RST_IN (rst_n),
    .bus    (bus),
    .D      (d)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Z80 IN cycle: returns D and IORQGE sampled mid-cycle
  task automatic z80_in(input logic [15:0] addr, input logic m1,
                        output logic [7:0] data, output logic ge);
    bus.A    = addr;
    bus.M1   = m1;
    bus.IORQ = 1'b0;
    bus.RD   = 1'b0;
    #2;
    data = d;
    ge   = bus.IORQGE;
    bus.IORQ = 1'b1;
    bus.RD   = 1'b1;
    #2;
  endtask

  // which: 0 MX, 1 MY, 2 MKEY, 3 JOY
  task automatic set_strobe(input int which, input logic v);
    case (which)
      0: bus.MX   = v;
      1: bus.MY   = v;
      2: bus.MKEY = v;
      default: bus.JOY = v;
    endcase
  endtask

  task automatic write_reg(input int which, input logic [7:0] val);
    bus.DI = val;
    tick(1);
    set_strobe(which, 1'b1);
    tick(4);
    set_strobe(which, 1'b0);
    tick(3);
  endtask

  task automatic kb_write(input int x, input int y, input logic v);
    logic [6:0] bits;
    bits = {y[2:0], x[3:0]};
    for (int i = 6; i >= 0; i--) begin
      bus.DAT = bits[i];
      tick(1);
      bus.SK = 1'b1;
      tick(3);
      bus.SK = 1'b0;
      tick(2);
    end
    bus.DAT = v;
    tick(1);
    bus.STB = 1'b1;
    tick(3);
    bus.STB = 1'b0;
    tick(3);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] rd;
  logic       ge;
  logic [7:0] hi_tab  [9];
  logic [7:0] exp_tab [9];

  initial begin
    bus.MX = 0; bus.MY = 0; bus.MKEY = 0; bus.JOY = 0; bus.DI = 8'h00;
    bus.JOY_ENABLE = 1'b1; bus.DAT = 0; bus.SK = 0; bus.STB = 0;
    bus.A = 16'h0000; bus.M1 = 1'b1; bus.RD = 1'b1; bus.IORQ = 1'b1;
    bus.TAPE_IN = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset values
    z80_in(16'hFBDF, 1'b1, rd, ge);
    check("rst_mx", rd, 8'h80);
    check("rst_mx_ge", {7'd0, ge}, 8'h01);
    z80_in(16'hFFDF, 1'b1, rd, ge);
    check("rst_my", rd, 8'h60);
    z80_in(16'hFADF, 1'b1, rd, ge);
    check("rst_mkey", rd, 8'hFF);
    bus.A = 16'hFBDF;
    #1;
    check("idle_ge", {7'd0, bus.IORQGE}, 8'h00);
    check("rst_nmi", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h00);

    // Mouse registers
    write_reg(0, 8'hCC);
    write_reg(1, 8'h55);
    write_reg(2, 8'hAA);
    z80_in(16'hFBDF, 1'b1, rd, ge);
    check("mx_cc", rd, 8'hCC);
    z80_in(16'hFFDF, 1'b1, rd, ge);
    check("my_55", rd, 8'h55);
    z80_in(16'hFADF, 1'b1, rd, ge);
    check("mkey_aa", rd, 8'hAA);
    write_reg(2, 8'h00);
    z80_in(16'hFADF, 1'b1, rd, ge);
    check("mkey_bit3", rd, 8'h08);

    // Simultaneous MX/MY strobes
    bus.DI = 8'h3C;
    tick(1);
    bus.MX = 1'b1; bus.MY = 1'b1;
    tick(4);
    bus.MX = 1'b0; bus.MY = 1'b0;
    tick(3);
    z80_in(16'hFBDF, 1'b1, rd, ge);
    check("sim_mx", rd, 8'h3C);
    z80_in(16'hFFDF, 1'b1, rd, ge);
    check("sim_my", rd, 8'h3C);

    // Joystick
    bus.JOY_ENABLE = 1'b0;
    write_reg(3, 8'hAA);
    z80_in(16'h001F, 1'b1, rd, ge);
    check("joy_aa", rd, 8'hAA);
    check("joy_ge", {7'd0, ge}, 8'h01);
    z80_in(16'h001F, 1'b0, rd, ge);
    check("joy_m1low_ge", {7'd0, ge}, 8'h00);
    bus.JOY_ENABLE = 1'b1;
    z80_in(16'h001F, 1'b1, rd, ge);
    check("joy_dis_ge", {7'd0, ge}, 8'h00);

    // Keyboard matrix
    kb_write(0, 0, 1'b1); kb_write(1, 1, 1'b1); kb_write(2, 2, 1'b1);
    kb_write(3, 1, 1'b1); kb_write(3, 3, 1'b1); kb_write(4, 4, 1'b1);
    kb_write(5, 3, 1'b1); kb_write(6, 2, 1'b1); kb_write(7, 1, 1'b1);
    kb_write(9, 0, 1'b1);  // outside the matrix: ignored

    hi_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'h3F};
    // {D7=1, D6=TAPE_IN=0, D5=1, cols}
    exp_tab = '{8'hBE, 8'hBD, 8'hBB, 8'hB5, 8'hAF, 8'hB7, 8'hBB, 8'hBD, 8'hB9};
    for (int i = 0; i < 9; i++) begin
      z80_in({hi_tab[i], 8'hFE}, 1'b1, rd, ge);
      check($sformatf("kb_row_%02h", hi_tab[i]), rd, exp_tab[i]);
    end
    z80_in(16'hFFFE, 1'b1, rd, ge);
    check("kb_none", rd, 8'hBF);
    bus.TAPE_IN = 1'b1;
    z80_in(16'hFFFE, 1'b1, rd, ge);
    check("kb_tape", rd, 8'hFF);
    bus.TAPE_IN = 1'b0;
    kb_write(0, 0, 1'b0);
    z80_in(16'hFEFE, 1'b1, rd, ge);
    check("kb_open", rd, 8'hBF);

    // Special keys
    kb_write(8, 5, 1'b1);
    check("nmi_set", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h04);
    kb_write(8, 6, 1'b1);
    check("rst_set", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h06);
    kb_write(8, 7, 1'b1);
    check("bsrq_set", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h07);
    kb_write(8, 5, 1'b0);
    check("nmi_clr", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h03);
    kb_write(8, 6, 1'b0);
    check("rst_clr", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h01);
    kb_write(8, 7, 1'b0);
    check("bsrq_clr", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h00);
    kb_write(8, 5, 1'b1);

    // One-cycle reset clears everything
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rst2_nmi", {5'd0, bus.NMI, bus.RST_OUT, bus.BSRQ}, 8'h00);
    z80_in(16'hFBDF, 1'b1, rd, ge);
    check("rst2_mx", rd, 8'h80);
    z80_in(16'hFFDF, 1'b1, rd, ge);
    check("rst2_my", rd, 8'h60);
    z80_in(16'hFADF, 1'b1, rd, ge);
    check("rst2_mkey", rd, 8'hFF);
    bus.JOY_ENABLE = 1'b0;
    z80_in(16'h001F, 1'b1, rd, ge);
    check("rst2_joy", rd, 8'h00);
    bus.JOY_ENABLE = 1'b1;
    z80_in(16'h00FE, 1'b1, rd, ge);
    check("rst2_kb", rd, 8'hBF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
